// File: rtl/process_run_queue.sv
// Run queue and two-core dispatcher.
// Runnable process descriptors are buffered in a circular FIFO. Each
// descriptor is offered to one free core at a time, and the starting core
// alternates between the two when both are idle. The block also reports when
// the system is fully quiescent so that the top level can raise its halt flag.
module process_run_queue #(
   parameter int addrBits  = 16,
   parameter int depthBits = 3
) (
   input  logic                clk,
   input  logic                reset,
   input  logic                enqueueValid,
   output logic                enqueueReady,
   input  logic [8:0]          enqueueJumpDestination,
   input  logic [addrBits-1:0] enqueueStackBase,
   output logic                core0StartValid,
   output logic [8:0]          core0StartJumpDestination,
   output logic [addrBits-1:0] core0StartStackBase,
   input  logic                core0StartAccept,
   input  logic                core0Retire,
   output logic                core1StartValid,
   output logic [8:0]          core1StartJumpDestination,
   output logic [addrBits-1:0] core1StartStackBase,
   input  logic                core1StartAccept,
   input  logic                core1Retire,
   output logic                core0Active,
   output logic                core1Active,
   output logic [depthBits:0]  queueCount,
   output logic                canHalt
);

   localparam int DEPTH = 1 << depthBits;
   localparam int EW    = 9 + addrBits;

   typedef enum logic {DISPATCH_IDLE, DISPATCH_OFFER} dispatch_state_t;

   // Queue storage and pointers. The pointers carry one extra bit so that
   // full and empty can be told apart when the low bits are equal.
   logic [EW-1:0]       mem [0:DEPTH-1];
   logic [depthBits:0]  head_reg, tail_reg;
   logic [depthBits:0]  count;
   logic                full, empty, push, pop;
   logic [EW-1:0]       head_entry;

   // Dispatcher state. Index 0 holds core 0 and index 1 holds core 1.
   dispatch_state_t             state_reg, state_next;
   logic                        target_reg, target_next;
   logic                        prio_reg, prio_next;
   logic [1:0]                  valid_reg, valid_next;
   logic [1:0]                  active_reg, active_next;
   logic [1:0][8:0]             jump_reg, jump_next;
   logic [1:0][addrBits-1:0]    stack_reg, stack_next;
   logic [1:0]                  accept;
   logic [1:0]                  retire;
   logic                        sel;

   assign count        = tail_reg - head_reg;
   assign full         = (count == (depthBits+1)'(DEPTH));
   assign empty        = (count == '0);
   // Readiness depends only on registered state, never on a pop in the same cycle.
   assign enqueueReady = !full;
   assign push         = enqueueValid && !full;
   assign head_entry   = mem[head_reg[depthBits-1:0]];
   assign accept       = {core1StartAccept, core0StartAccept};
   assign retire       = {core1Retire, core0Retire};

   // Write accepted descriptors at the tail. The contents are not reset
   // because the pointers determine which entries are valid.
   always_ff @(posedge clk) begin
      if (push)
         mem[tail_reg[depthBits-1:0]] <= {enqueueJumpDestination, enqueueStackBase};
   end

   // Advance the head and tail pointers on each pop and push.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         head_reg <= '0;
         tail_reg <= '0;
      end else begin
         if (push) tail_reg <= tail_reg + 1'b1;
         if (pop)  head_reg <= head_reg + 1'b1;
      end
   end

   // Dispatcher state register, together with the per-core offer and occupancy registers.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_reg  <= DISPATCH_IDLE;
         target_reg <= 1'b0;
         prio_reg   <= 1'b0;
         valid_reg  <= '0;
         active_reg <= '0;
         jump_reg   <= '0;
         stack_reg  <= '0;
      end else begin
         state_reg  <= state_next;
         target_reg <= target_next;
         prio_reg   <= prio_next;
         valid_reg  <= valid_next;
         active_reg <= active_next;
         jump_reg   <= jump_next;
         stack_reg  <= stack_next;
      end
   end

   // Next-state logic: pick a free core, hold the offer until that core accepts it, and apply retirements.
   always_comb begin
      state_next  = state_reg;
      target_next = target_reg;
      prio_next   = prio_reg;
      valid_next  = valid_reg;
      jump_next   = jump_reg;
      stack_next  = stack_reg;
      // A retire on a core that is not active has no effect.
      active_next = active_reg & ~retire;
      pop         = 1'b0;
      // When both cores are idle, the priority bit picks the core. Otherwise the one idle core is picked.
      sel         = (active_reg == 2'b00) ? prio_reg : active_reg[0];
      case (state_reg)
         DISPATCH_IDLE: begin
            if (!empty && (active_reg != 2'b11)) begin
               pop             = 1'b1;
               jump_next[sel]  = head_entry[EW-1 -: 9];
               stack_next[sel] = head_entry[addrBits-1:0];
               valid_next[sel] = 1'b1;
               target_next     = sel;
               state_next      = DISPATCH_OFFER;
            end
         end
         DISPATCH_OFFER: begin
            if (accept[target_reg]) begin
               valid_next[target_reg]  = 1'b0;
               active_next[target_reg] = 1'b1;
               prio_next               = ~target_reg;
               state_next              = DISPATCH_IDLE;
            end
         end
         default: state_next = DISPATCH_IDLE;
      endcase
   end

   assign core0StartValid           = valid_reg[0];
   assign core0StartJumpDestination = jump_reg[0];
   assign core0StartStackBase       = stack_reg[0];
   assign core1StartValid           = valid_reg[1];
   assign core1StartJumpDestination = jump_reg[1];
   assign core1StartStackBase       = stack_reg[1];
   assign core0Active               = active_reg[0];
   assign core1Active               = active_reg[1];
   assign queueCount                = count;
   assign canHalt = empty && (state_reg == DISPATCH_IDLE) && (active_reg == 2'b00) && !enqueueValid;

endmodule

// File: tb/tb_process_run_queue.sv
// Directed testbench for process_run_queue. Each expected value is worked out
// by hand from the dispatch timing of the block.
module tb_process_run_queue;

   logic        clk = 1'b0;
   logic        reset = 1'b1;
   logic        enqueueValid = 1'b0;
   logic        enqueueReady;
   logic [8:0]  ejd = '0;
   logic [15:0] esb = '0;
   logic        c0v, c1v, c0a, c1a, canHalt;
   logic [8:0]  c0j, c1j;
   logic [15:0] c0s, c1s;
   logic        c0acc = 1'b0, c1acc = 1'b0, c0ret = 1'b0, c1ret = 1'b0;
   logic [3:0]  queueCount;

   int n_vec = 0;
   int n_err = 0;

   always #5 clk = ~clk;

   process_run_queue #(.addrBits(16), .depthBits(3)) dut (
      .clk(clk), .reset(reset),
      .enqueueValid(enqueueValid), .enqueueReady(enqueueReady),
      .enqueueJumpDestination(ejd), .enqueueStackBase(esb),
      .core0StartValid(c0v), .core0StartJumpDestination(c0j), .core0StartStackBase(c0s),
      .core0StartAccept(c0acc), .core0Retire(c0ret),
      .core1StartValid(c1v), .core1StartJumpDestination(c1j), .core1StartStackBase(c1s),
      .core1StartAccept(c1acc), .core1Retire(c1ret),
      .core0Active(c0a), .core1Active(c1a),
      .queueCount(queueCount), .canHalt(canHalt)
   );

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_vec++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end else
         $display("ok   %s: %0h", tag, got);
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic enq(input logic [8:0] j, input logic [15:0] s);
      enqueueValid = 1'b1; ejd = j; esb = s;
      tick();
      enqueueValid = 1'b0;
   endtask

   task automatic do_reset();
      reset = 1'b1;
      tick(); tick();
      reset = 1'b0;
   endtask

   task automatic retire(input int core);
      if (core == 0) c0ret = 1'b1; else c1ret = 1'b1;
      tick();
      c0ret = 1'b0; c1ret = 1'b0;
   endtask

   // Wait a bounded number of cycles for an offer on the given core, then check the offered data and accept it.
   task automatic take(input int core, input logic [8:0] j, input logic [15:0] s, input string tag);
      int  n = 0;
      bit  other = 1'b0;
      while (!((core == 0) ? c0v : c1v) && n < 50) begin
         if ((core == 0) ? c1v : c0v) other = 1'b1;
         tick();
         n++;
      end
      check({tag, ".valid"}, 32'((core == 0) ? c0v : c1v), 32'd1);
      check({tag, ".other_valid"}, 32'(other | ((core == 0) ? c1v : c0v)), 32'd0);
      check({tag, ".jump"}, 32'((core == 0) ? c0j : c1j), 32'(j));
      check({tag, ".stack"}, 32'((core == 0) ? c0s : c1s), 32'(s));
      if (core == 0) c0acc = 1'b1; else c1acc = 1'b1;
      tick();
      c0acc = 1'b0; c1acc = 1'b0;
      check({tag, ".active"}, 32'((core == 0) ? c0a : c1a), 32'd1);
   endtask

   initial begin
      // Check the reset values.
      tick(); tick();
      check("rst.ready", 32'(enqueueReady), 32'd1);
      check("rst.valids", 32'({c0v, c1v}), 32'd0);
      check("rst.active", 32'({c0a, c1a}), 32'd0);
      check("rst.count", 32'(queueCount), 32'd0);
      check("rst.canhalt", 32'(canHalt), 32'd1);
      check("rst.data", 32'({c0j, c1j}), 32'd0);
      reset = 1'b0;

      // Dispatch a single descriptor to core 0.
      enq(9'd0, 16'h0000);
      check("t1.count_after_enq", 32'(queueCount), 32'd1);
      check("t1.no_offer_yet", 32'(c0v), 32'd0);
      tick();
      check("t1.offer", 32'({c0v, c1v}), 32'b10);
      check("t1.count_after_pop", 32'(queueCount), 32'd0);
      take(0, 9'd0, 16'h0000, "t1");
      check("t1.count", 32'(queueCount), 32'd0);
      check("t1.canhalt_busy", 32'(canHalt), 32'd0);
      retire(0);
      check("t1.canhalt_done", 32'(canHalt), 32'd1);

      // Two back-to-back descriptors should alternate between the cores.
      do_reset();
      enqueueValid = 1'b1; ejd = 9'd5; esb = 16'h0105;
      tick();
      ejd = 9'd9; esb = 16'h0209;
      tick();
      enqueueValid = 1'b0;
      check("t2.A_offer", 32'({c0v, c0j}), {22'd0, 1'b1, 9'd5});
      check("t2.count", 32'(queueCount), 32'd1);
      take(0, 9'd5, 16'h0105, "t2.A");
      check("t2.idle_gap", 32'(c1v), 32'd0);
      take(1, 9'd9, 16'h0209, "t2.B");
      c0ret = 1'b1; c1ret = 1'b1;
      tick();
      c0ret = 1'b0; c1ret = 1'b0;
      check("t2.both_retired", 32'({c0a, c1a}), 32'd0);
      check("t2.canhalt", 32'(canHalt), 32'd1);
      enq(9'd3, 16'h0333);
      take(0, 9'd3, 16'h0333, "t2.C");

      // Core 0 is busy, so the next descriptor must go to core 1.
      enq(9'd4, 16'h0444);
      take(1, 9'd4, 16'h0444, "t3.D");

      // Fill the queue while both cores are busy.
      for (int i = 0; i < 8; i++) enq(9'(16 + i), 16'(16'h1000 + i));
      check("t4.count_full", 32'(queueCount), 32'd8);
      check("t4.ready_full", 32'(enqueueReady), 32'd0);
      enqueueValid = 1'b1; ejd = 9'd24; esb = 16'h1008;
      tick(); tick(); tick();
      check("t4.refused_count", 32'(queueCount), 32'd8);
      check("t4.refused_ready", 32'(enqueueReady), 32'd0);
      c1ret = 1'b1;
      tick();
      c1ret = 1'b0;
      check("t4.after_retire_count", 32'(queueCount), 32'd8);
      tick();
      check("t4.pop_ready", 32'(enqueueReady), 32'd1);
      check("t4.pop_count", 32'(queueCount), 32'd7);
      check("t4.pop_offer", 32'({c1v, c1j}), {22'd0, 1'b1, 9'd16});
      tick();
      enqueueValid = 1'b0;
      check("t4.ninth_in", 32'(queueCount), 32'd8);
      for (int i = 0; i < 9; i++) begin
         take(1, 9'(16 + i), 16'(16'h1000 + i), $sformatf("t4.e%0d", i));
         retire(1);
      end
      check("t4.drained", 32'(queueCount), 32'd0);

      // Hold an offer unaccepted while three more descriptors are queued.
      retire(0);
      enq(9'd40, 16'h4040);
      tick();
      for (int cyc = 0; cyc < 20; cyc++) begin
         if (cyc < 3) begin
            enqueueValid = 1'b1; ejd = 9'(41 + cyc); esb = 16'(16'h4041 + cyc);
         end else
            enqueueValid = 1'b0;
         tick();
         check($sformatf("t5.hold%0d", cyc), {5'd0, c0v, c1v, c0j, c0s}, {5'd0, 1'b1, 1'b0, 9'd40, 16'h4040});
      end
      enqueueValid = 1'b0;
      check("t5.count", 32'(queueCount), 32'd3);

      // Apply reset while an offer is pending, with core 1 active and 4 entries queued.
      take(0, 9'd40, 16'h4040, "t6.E");
      take(1, 9'd41, 16'h4041, "t6.F");
      retire(0);
      tick();
      check("t6.G_offer", 32'({c0v, c0j}), {22'd0, 1'b1, 9'd42});
      for (int i = 0; i < 3; i++) enq(9'(50 + i), 16'(16'h5000 + i));
      check("t6.count4", 32'(queueCount), 32'd4);
      check("t6.core1_active", 32'(c1a), 32'd1);
      #2 reset = 1'b1;
      #1;
      check("t6.async_valids", 32'({c0v, c1v}), 32'd0);
      check("t6.async_active", 32'({c0a, c1a}), 32'd0);
      check("t6.async_count", 32'(queueCount), 32'd0);
      check("t6.async_ready", 32'(enqueueReady), 32'd1);
      tick();
      reset = 1'b0;
      enq(9'd7, 16'h0077);
      take(0, 9'd7, 16'h0077, "t6.H");

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

   // Safety net so that the run always terminates.
   initial begin
      #200000;
      $display("FAIL watchdog: got timeout expected completion");
      $fatal(1);
   end

endmodule

// File: doc/process_run_queue.md
# process_run_queue

Ready-process run queue and dispatcher for the dual-core processor. Holds up to 2^depthBits runnable process descriptors (jump destination + stack base) posted by the processor message handler, and dispatches them to whichever core is free, with round-robin priority between the two cores. It tracks per-core occupancy and produces the halt condition the top level uses to assert `finished`.

## Interface

Parameters:
- addrBits, 16, width of stack-base field
- depthBits, 3, log2 of queue depth (default 8 entries)

Ports:
- clk  input  1  clock, all state on rising edge
- reset  input  1  asynchronous, active-high; clears all state
- enqueueValid  input  1  descriptor offered this cycle
- enqueueReady  output  1  queue not full; enqueue occurs on the edge where enqueueValid && enqueueReady
- enqueueJumpDestination  input  9  process entry point
- enqueueStackBase  input  addrBits  process stack base
- core0StartValid  output  1  descriptor offered to core 0
- core0StartJumpDestination  output  9  held stable while core0StartValid
- core0StartStackBase  output  addrBits  held stable while core0StartValid
- core0StartAccept  input  1  core 0 takes descriptor
- core0Retire  input  1  one-cycle pulse: core 0 process terminated/descheduled
- core1StartValid, core1StartJumpDestination, core1StartStackBase, core1StartAccept, core1Retire: as core 0
- core0Active  output  1  core 0 running a dispatched process
- core1Active  output  1  core 1 running a dispatched process
- queueCount  output  depthBits+1  entries currently stored
- canHalt  output  1  nothing queued, nothing offered, nothing running

## Operation

- Storage: circular buffer of 2^depthBits entries, {jump[8:0], stackBase}; head/tail pointers depthBits+1 bits wide; wrap via MSB. full = count == 2^depthBits; empty = count == 0.
- enqueueReady = !full, from registered count only (no combinational dependence on same-cycle pop).
- Dispatcher FSM, two states:
  - DISPATCH_IDLE: if !empty and at least one core inactive, select target: if both inactive, core given by priority bit (0 = core0); otherwise the inactive core. Latch head entry into that core's Start registers, pop, set its StartValid, go to DISPATCH_OFFER.
  - DISPATCH_OFFER: hold StartValid and data stable. On target's StartAccept: clear StartValid, set target Active, set priority to the other core, return to DISPATCH_IDLE. No timeout; offer held indefinitely.
- At most one StartValid high at any time; never for an Active core.
- Retire: coreNRetire clears coreNActive on that edge. Retire for an inactive core is ignored. Retire of core X and accept on core Y in the same cycle both take effect.
- Enqueue and pop in the same cycle: count unchanged, both pointers advance; entry order preserved (strict FIFO).
- canHalt = empty && state == DISPATCH_IDLE && !core0Active && !core1Active && !enqueueValid (combinational).
- Reset mid-offer or mid-run: all queued descriptors discarded, Active flags cleared, StartValid deasserted immediately (asynchronous).

## Timing

- Reset values: enqueueReady 1, core0/1StartValid 0, Start data 0, core0/1Active 0, queueCount 0, canHalt 1 when enqueueValid low; FSM DISPATCH_IDLE, priority 0.
- Enqueue at edge t: queueCount increments visible after t; earliest dispatch decision at edge t+1; StartValid high from t+1 to accept.
- Accept at edge a: Active high after a; next dispatch decision possible at edge a+1 (one idle cycle between dispatches, so max throughput one dispatch per 2 cycles).
- Retire at edge r: Active low after r; that core eligible for dispatch at edge r+1.
- Full queue: enqueueReady low while count == 2^depthBits; a pop at edge p raises enqueueReady after p.

## Test plan

- Reset, then enqueue one descriptor {jump 0, stack 0} with both cores idle -> core0StartValid high next cycle with jump 0; assert core0StartAccept -> core0Active=1, queueCount=0, canHalt=0; pulse core0Retire -> canHalt=1.
- Enqueue A(jump 5), B(jump 9) back-to-back, both cores idle -> A offered to core 0, after accept B offered to core 1; next single descriptor C after both retire goes to core 0 (priority alternated twice).
- Core 0 Active, enqueue D -> D offered to core 1 regardless of priority bit; core 0 never sees StartValid.
- Fill 8 entries with both cores Active -> enqueueReady=0, queueCount=8, 9th enqueueValid held and refused; retire core 1 -> head entry popped to core 1, enqueueReady=1 next cycle, 9th accepted; all 9 dispatched in enqueue order.
- Hold offer with core0StartAccept low for 20 cycles while enqueuing 3 more -> Start data stable throughout, no second StartValid, queueCount=3.
- Assert reset during an offer with 4 entries queued and core 1 Active -> all StartValid/Active 0 immediately, queueCount=0, enqueueReady=1; subsequent enqueue dispatches to core 0.
